// File: rtl/shift_unit_seq_if.sv
// Request/response bundle between the control unit (master) and the shift unit (slave).
interface shift_unit_seq_if #(
  parameter int unsigned WIDTH = 32
);
  localparam int unsigned SW = $clog2(WIDTH);

  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] Ra;
  logic [SW-1:0]    shift_amt;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             illegal;

  modport master (
    output start, op, Ra, shift_amt,
    input  busy, done, result, illegal
  );

  modport slave (
    input  start, op, Ra, shift_amt,
    output busy, done, result, illegal
  );
endinterface

// File: rtl/shift_unit_seq.sv
// Multi-cycle shift/rotate unit: moves at most STEP bit positions per clock,
// start/busy/done handshake, result and illegal flag held until the next completion.
module shift_unit_seq #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned STEP  = 4
) (
  input logic             clock,
  input logic             clear,
  shift_unit_seq_if.slave bus
);
  localparam int unsigned SW = $clog2(WIDTH);
  localparam logic [SW-1:0] StepV = SW'(STEP);
  localparam logic [SW:0]   WidthV = (SW+1)'(WIDTH);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [SW-1:0]    remaining_q, remaining_d;
  logic [2:0]       op_q, op_d;
  logic             sign_q, sign_d;
  logic             illegal_q, illegal_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             illegal_out_q, illegal_out_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [SW-1:0]    n;
  logic [SW:0]      nb;
  logic [WIDTH-1:0] step_val;

  // One step of the selected operation by n = min(remaining, STEP) positions.
  always_comb begin
    n  = (remaining_q < StepV) ? remaining_q : StepV;
    // Complementary distance for the wrap-around half of a rotate; only used when n != 0.
    nb = WidthV - {1'b0, n};
    case (op_q)
      3'd0:    step_val = (acc_q << n) | (acc_q >> nb);
      3'd1:    step_val = (acc_q >> n) | (acc_q << nb);
      3'd2:    step_val = acc_q << n;
      3'd3:    step_val = acc_q >> n;
      // SHRA fills with the sign captured at start, not the current acc MSB.
      default: step_val = (acc_q >> n) |
                          ({WIDTH{sign_q}} & ~({WIDTH{1'b1}} >> n));
    endcase
  end

  // Next-state and next-output computation for the IDLE/BUSY/DONE sequencer.
  always_comb begin
    state_d       = state_q;
    acc_d         = acc_q;
    remaining_d   = remaining_q;
    op_d          = op_q;
    sign_d        = sign_q;
    illegal_d     = illegal_q;
    result_d      = result_q;
    illegal_out_d = illegal_out_q;

    unique case (state_q)
      StIdle, StDone: begin
        if (bus.start) begin
          state_d = StBusy;
          acc_d   = bus.Ra;
          op_d    = bus.op;
          sign_d  = bus.Ra[WIDTH-1];
          if (bus.op > 3'd4) begin
            remaining_d = '0;
            illegal_d   = 1'b1;
          end else begin
            remaining_d = bus.shift_amt;
            illegal_d   = 1'b0;
          end
        end else begin
          state_d = StIdle;
        end
      end
      StBusy: begin
        if (remaining_q != '0) begin
          acc_d       = step_val;
          remaining_d = remaining_q - n;
        end else begin
          state_d       = StDone;
          result_d      = acc_q;
          illegal_out_d = illegal_q;
        end
      end
      default: state_d = StIdle;
    endcase

    // Handshake outputs are decoded from the next state so they can be registered.
    busy_d = (state_d == StBusy);
    done_d = (state_d == StDone);
  end

  // State and output registers with synchronous clear.
  always_ff @(posedge clock) begin
    if (clear) begin
      state_q       <= StIdle;
      acc_q         <= '0;
      remaining_q   <= '0;
      op_q          <= '0;
      sign_q        <= 1'b0;
      illegal_q     <= 1'b0;
      result_q      <= '0;
      illegal_out_q <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      acc_q         <= acc_d;
      remaining_q   <= remaining_d;
      op_q          <= op_d;
      sign_q        <= sign_d;
      illegal_q     <= illegal_d;
      result_q      <= result_d;
      illegal_out_q <= illegal_out_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.result  = result_q;
  assign bus.illegal = illegal_out_q;
endmodule
